// File: rtl/ram_cmd_pkg.sv
// Shared encodings for the CLI memory-command stage.
// Op codes, FSM state codes and default geometry.
package ram_cmd_pkg;

    localparam int DEPTH_DEF  = 1024;
    localparam int LEN_W_DEF  = 16;
    localparam int RD_LAT_DEF = 1;

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;
    localparam logic [1:0] OP_DUMP  = 2'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR      = 3'd1;
    localparam state_t ST_RD_REQ  = 3'd2;
    localparam state_t ST_RD_WAIT = 3'd3;
    localparam state_t ST_RESP    = 3'd4;

    function automatic logic is_multi(input logic [1:0] op);
        return (op == OP_FILL) || (op == OP_DUMP);
    endfunction

    function automatic logic is_write(input logic [1:0] op);
        return (op == OP_WRITE) || (op == OP_FILL);
    endfunction

    function automatic logic is_single(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/ram_addr_walker.sv
// Address walker: start-address load, modulo-DEPTH increment,
// remaining-word counter and last-word flag.
module ram_addr_walker
    import ram_cmd_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      start_addr,
    input  logic [LEN_W-1:0] len,
    output logic [31:0]      addr,
    output logic [31:0]      base,
    output logic [LEN_W-1:0] total,
    output logic             last
);

    localparam logic [31:0] ADDR_MAX = 32'(DEPTH - 1);

    logic [31:0]      addr_q;
    logic [31:0]      base_q;
    logic [LEN_W-1:0] total_q;
    logic [LEN_W-1:0] remain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            base_q   <= '0;
            total_q  <= '0;
            remain_q <= '0;
        end else if (load) begin
            addr_q   <= start_addr;
            base_q   <= start_addr;
            total_q  <= len;
            remain_q <= len;
        end else if (step) begin
            addr_q   <= (addr_q == ADDR_MAX) ? '0 : addr_q + 32'd1;
            remain_q <= remain_q - LEN_W'(1);
        end
    end

    // Counting down from len means the full LEN_W range fits.
    assign last  = (remain_q == LEN_W'(1));
    assign addr  = addr_q;
    assign base  = base_q;
    assign total = total_q;

endmodule

// File: rtl/ram_cmd_ctrl.sv
// Memory-command execution stage in front of sp_ram_rw:
// runs READ/WRITE/FILL/DUMP and returns data or acks.
module ram_cmd_ctrl
    import ram_cmd_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int RD_LAT = RD_LAT_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [31:0]      rsp_addr,
    output logic             rsp_last,
    output logic             rsp_err,
    output logic [31:0]      ram_address,
    output logic [31:0]      ram_data_in,
    output logic             ram_re,
    output logic             ram_we,
    input  logic [31:0]      ram_data_out,
    output logic             busy
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RD_LAT - 1);

    state_t           state_q;
    logic [31:0]      data_q;
    logic [WAIT_W-1:0] wait_q;
    logic [31:0]      rsp_data_q;
    logic [31:0]      rsp_addr_q;
    logic             rsp_last_q;
    logic             rsp_err_q;

    logic             cmd_fire;
    logic             cmd_bad;
    logic [LEN_W-1:0] len_eff;
    logic             w_step;
    logic [31:0]      w_addr;
    logic [31:0]      w_base;
    logic [LEN_W-1:0] w_total;
    logic             w_last;

    assign cmd_ready = (state_q == ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_bad   = (cmd_addr >= 32'(DEPTH)) ||
                       (is_multi(cmd_op) && (cmd_len == '0));
    assign len_eff   = is_single(cmd_op) ? LEN_W'(1) : cmd_len;

    // Reads advance only once the consumer takes the current word.
    assign w_step = (state_q == ST_WR) ||
                    ((state_q == ST_RESP) && rsp_ready && !rsp_last_q);

    ram_addr_walker #(
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) u_walker (
        .clk        (clk),
        .rst        (rst),
        .load       (cmd_fire && !cmd_bad),
        .step       (w_step),
        .start_addr (cmd_addr),
        .len        (len_eff),
        .addr       (w_addr),
        .base       (w_base),
        .total      (w_total),
        .last       (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            wait_q     <= '0;
            rsp_data_q <= '0;
            rsp_addr_q <= '0;
            rsp_last_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        data_q <= cmd_data;
                        if (cmd_bad) begin
                            rsp_data_q <= '0;
                            rsp_addr_q <= cmd_addr;
                            rsp_last_q <= 1'b1;
                            rsp_err_q  <= 1'b1;
                            state_q    <= ST_RESP;
                        end else begin
                            rsp_err_q <= 1'b0;
                            state_q   <= is_write(cmd_op) ? ST_WR
                                                          : ST_RD_REQ;
                        end
                    end
                end
                ST_WR: begin
                    if (w_last) begin
                        rsp_data_q <= 32'(w_total);
                        rsp_addr_q <= w_base;
                        rsp_last_q <= 1'b1;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RD_REQ: begin
                    wait_q  <= '0;
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (wait_q == WAIT_END) begin
                        rsp_data_q <= ram_data_out;
                        rsp_addr_q <= w_addr;
                        rsp_last_q <= w_last;
                        state_q    <= ST_RESP;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= rsp_last_q ? ST_IDLE : ST_RD_REQ;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ram_we      = (state_q == ST_WR);
    assign ram_re      = (state_q == ST_RD_REQ);
    assign ram_address = (ram_we || ram_re) ? w_addr : '0;
    assign ram_data_in = ram_we ? data_q : '0;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_last  = rsp_last_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/ram_cmd_ctrl.md
Name: ram_cmd_ctrl

Overview:
- Command-execution stage directly upstream of sp_ram_rw: takes decoded CLI memory commands (read, write, fill, dump) over a valid/ready handshake.
- Sequences the RAM's address/data_in/re/we pins and returns read data or write acknowledgements to the CLI response path over a second valid/ready handshake.
- One command in flight at a time. Multi-word ops walk consecutive addresses.

Parameters:
- DEPTH, 1024, number of valid RAM words; legal addresses 0..DEPTH-1.
- RD_LAT, 1, cycles from ram_re sampled high to ram_data_out valid.
- LEN_W, 16, width of the command word-count field.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller accepts command (high only in IDLE)
- cmd_op  in  2  0=READ, 1=WRITE, 2=FILL, 3=DUMP
- cmd_addr  in  32  start word address
- cmd_data  in  32  write/fill value
- cmd_len  in  LEN_W  word count (FILL/DUMP only; ignored for READ/WRITE)
- rsp_valid  out  1  response word present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  read data, or word count written for WRITE/FILL
- rsp_addr  out  32  address of the word (start address for acks)
- rsp_last  out  1  final response of the command
- rsp_err  out  1  command rejected; valid with rsp_valid
- ram_address  out  32  to sp_ram_rw address
- ram_data_in  out  32  to sp_ram_rw data_in
- ram_re  out  1  to sp_ram_rw re
- ram_we  out  1  to sp_ram_rw we
- ram_data_out  in  32  from sp_ram_rw data_out
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE. cmd_ready=1 (the IDLE value, from the first cycle after reset). All other outputs are 0.
- Reset mid-command: the command is abandoned, and ram_we/ram_re drop on the reset edge. No response is issued.
- Accept: the command is latched on the clk edge where cmd_valid and cmd_ready are both high.
- Validation at accept:
  - Reject if cmd_addr >= DEPTH, or if op is FILL/DUMP with cmd_len==0.
  - Rejection goes to RESP with rsp_err=1, rsp_last=1, rsp_data=0, rsp_addr=cmd_addr.
  - A rejected command makes no RAM access.
- Address increment: wraps modulo DEPTH (DEPTH-1 -> 0). rsp_addr reports the wrapped address.
- States: IDLE, WR, RD_REQ, RD_WAIT, RESP.
- WRITE/FILL:
  - In WR, ram_we=1 with ram_address=current address and ram_data_in=cmd_data, one word per cycle.
  - WRITE does 1 word; FILL does cmd_len words on consecutive cycles.
  - After the last word -> RESP with rsp_data=word count, rsp_addr=start address, rsp_last=1.
- READ/DUMP, per word:
  - RD_REQ: ram_re=1 for exactly one cycle.
  - RD_WAIT: hold for RD_LAT cycles, then capture ram_data_out into the rsp_data register.
  - RESP: rsp_valid=1; hold all rsp_* stable until rsp_ready.
  - On handshake: if more words remain, advance address -> RD_REQ; else -> IDLE.
  - rsp_last=1 only on the final word (word 1 for READ, word cmd_len for DUMP).
- ram_re and ram_we are never high in the same cycle. Both are 0 outside WR/RD_REQ.
- The response handshake completes on the edge where rsp_valid and rsp_ready are both high. The next state is taken that same edge, so rsp_valid drops the following cycle unless another word is ready.
- rsp_ready held high during DUMP: throughput is one word per (RD_LAT+2) cycles; no pipelining.
- Word counter is LEN_W wide. cmd_len=2^LEN_W-1 must complete without overflow.
- Inputs cmd_* are ignored outside IDLE.

Decomposition:
- Package ram_cmd_pkg holds:
  - op encodings OP_READ/OP_WRITE/OP_FILL/OP_DUMP;
  - the state enum;
  - default DEPTH/LEN_W constants.
- One natural sub-module: ram_addr_walker (start-address load, modulo-DEPTH increment, remaining-word counter, last flag).
- The FSM and response register stay in the top.

Test Plan:
- WRITE addr=1 data=111, then READ addr=1 -> one ack (rsp_data=1, rsp_last=1), then rsp_data=111, rsp_addr=1, rsp_last=1, rsp_err=0.
- FILL addr=DEPTH-2 len=4 data=0xA5A5A5A5, then DUMP same -> 4 words 0xA5A5A5A5 at addrs 1022,1023,0,1 with rsp_last only on the 4th; ack rsp_data=4.
- READ addr=DEPTH, and DUMP len=0 -> rsp_err=1, rsp_last=1; ram_re/ram_we never asserted.
- DUMP len=3 with rsp_ready toggled randomly -> rsp_data/rsp_addr stable while stalled; exactly 3 handshakes; no extra ram_re pulses.
- Assert rst during the 2nd word of FILL len=8 -> ram_we=0 next cycle, busy=0, cmd_ready=1, rsp_valid never asserted.
- Back-to-back commands with cmd_valid held high -> cmd_ready low from accept until the final response handshake; the second command is accepted the cycle after.
